// File: rtl/apb3_dm_pkg.sv
// Shared definitions for the APB3 debug-module register block: offsets, FSM encoding,
// CTRL bit positions, default ID and the STATUS composition helper.
package apb3_dm_pkg;

  localparam logic [7:0] OFF_CTRL       = 8'h00;
  localparam logic [7:0] OFF_STATUS     = 8'h04;
  localparam logic [7:0] OFF_SCRATCH    = 8'h08;
  localparam logic [7:0] OFF_FIFO_DATA  = 8'h0C;
  localparam logic [7:0] OFF_FIFO_LEVEL = 8'h10;
  localparam logic [7:0] OFF_ID         = 8'h14;

  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_OVF_CLR_BIT = 1;

  localparam logic [31:0] DM_ID_DEFAULT = 32'h444D_0102;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_STALL  = 2'b10
  } dm_state_e;

  function automatic logic [31:0] compose_status(input logic [15:0] live, input logic ovf,
                                                 input logic full, input logic empty);
    return {live, 13'h0, ovf, full, empty};
  endfunction

endpackage

// File: rtl/dm_sync_fifo.sv
// Synchronous command FIFO with wrapping pointers and a separate occupancy counter.
// Flush empties it in one cycle and wins over a same-cycle push or pop.
module dm_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty && !flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = count;

  // Storage array: written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb3_dm_regs.sv
// APB3 register block with CTRL/STATUS/SCRATCH/ID and a command FIFO push port.
// Define DM_FIFO_STALL_EN to wait-state full-FIFO pushes instead of dropping them.
module apb3_dm_regs
  import apb3_dm_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] ID_VALUE   = DM_ID_DEFAULT
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic [15:0] status_in,
  output logic [31:0] ctrl_out,
  output logic [31:0] fifo_dout,
  output logic        fifo_valid,
  input  logic        fifo_ready
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  dm_state_e        state;
  dm_state_e        state_nxt;
  logic [31:0]      ctrl_r;
  logic [31:0]      scratch_r;
  logic             ovf_r;
  logic [7:0]       addr_off;
  logic             unused_addr_bits;
  logic             mapped;
  logic             is_ro;
  logic             is_wo;
  logic [31:0]      rdata_sel;
  logic             in_xfer;
  logic             fifo_wr;
  logic             pop;
  logic             blocked;
  logic             drop;
  logic             err;
  logic             complete;
  logic             wr_ok;
  logic             ctrl_wr;
  logic             push;
  logic             flush;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LW-1:0]    fifo_level;

  assign addr_off         = {PADDR[7:2], 2'b00};
  assign unused_addr_bits = ^PADDR[1:0];

  // Register decode and read-data selection.
  always_comb begin
    mapped    = 1'b1;
    is_ro     = 1'b0;
    is_wo     = 1'b0;
    rdata_sel = 32'h0;
    case (addr_off)
      OFF_CTRL:       rdata_sel = {ctrl_r[31:2], 2'b00};
      OFF_STATUS: begin
        is_ro     = 1'b1;
        rdata_sel = compose_status(status_in, ovf_r, fifo_full, fifo_empty);
      end
      OFF_SCRATCH:    rdata_sel = scratch_r;
      OFF_FIFO_DATA:  is_wo = 1'b1;
      OFF_FIFO_LEVEL: begin
        is_ro     = 1'b1;
        rdata_sel = 32'(fifo_level);
      end
      OFF_ID: begin
        is_ro     = 1'b1;
        rdata_sel = ID_VALUE;
      end
      default:        mapped = 1'b0;
    endcase
  end

  assign pop     = fifo_valid && fifo_ready;
  assign in_xfer = PSEL && PENABLE && (state != ST_IDLE);
  assign fifo_wr = PWRITE && (addr_off == OFF_FIFO_DATA);
  assign blocked = fifo_wr && fifo_full && !pop;

  // Completion response; decided in the access cycle itself so a same-cycle pop can make room.
  always_comb begin
    PREADY = 1'b1;
    drop   = 1'b0;
`ifdef DM_FIFO_STALL_EN
    if (in_xfer && blocked) begin
      PREADY = 1'b0;
    end else begin
      PREADY = 1'b1;
    end
`else
    drop = blocked;
`endif
    err = !mapped || (PWRITE && is_ro) || (!PWRITE && is_wo) || drop;
  end

  assign complete = in_xfer && PREADY;
  assign PSLVERR  = complete && err;
  assign PRDATA   = (complete && !PWRITE && !err) ? rdata_sel : 32'h0;
  assign wr_ok    = complete && PWRITE && !err;
  assign ctrl_wr  = wr_ok && (addr_off == OFF_CTRL);
  assign push     = wr_ok && fifo_wr;
  assign flush    = ctrl_wr && PWDATA[CTRL_FLUSH_BIT];

  // FSM state register.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state; a dropped PSEL mid-transfer falls back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (PSEL && !PENABLE) state_nxt = ST_ACCESS;
        else                  state_nxt = ST_IDLE;
      end
      ST_ACCESS: begin
`ifdef DM_FIFO_STALL_EN
        if (in_xfer && !PREADY) state_nxt = ST_STALL;
        else                    state_nxt = ST_IDLE;
`else
        state_nxt = ST_IDLE;
`endif
      end
`ifdef DM_FIFO_STALL_EN
      ST_STALL: begin
        if (in_xfer && !PREADY) state_nxt = ST_STALL;
        else                    state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Register file; CTRL pulse bits act on the write and clear one cycle later.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      ctrl_r    <= 32'h0;
      scratch_r <= 32'h0;
      ovf_r     <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl_r <= PWDATA;
      else         ctrl_r <= {ctrl_r[31:2], 2'b00};
      if (wr_ok && (addr_off == OFF_SCRATCH)) scratch_r <= PWDATA;
      if (complete && drop)                          ovf_r <= 1'b1;
      else if (ctrl_wr && PWDATA[CTRL_OVF_CLR_BIT])  ovf_r <= 1'b0;
    end
  end

  assign ctrl_out   = ctrl_r;
  assign fifo_valid = !fifo_empty;

  dm_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESETN),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (PWDATA),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_apb3_dm_regs.sv
// Directed bench for apb3_dm_regs: a register vector table plus FIFO, overflow/stall,
// flush and mid-transfer reset sequences.
module tb_apb3_dm_regs;
  logic        PCLK = 1'b0;
  logic        PRESETN;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [15:0] status_in;
  logic [31:0] ctrl_out;
  logic [31:0] fifo_dout;
  logic        fifo_valid;
  logic        fifo_ready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t        vt [18];
  logic [31:0] rd;
  logic        er;
  int          w;
  int          lows;
  int          got;
  int          errs_fill;
  logic [31:0] first_w;
  logic [31:0] last_w;

  always #5 PCLK = ~PCLK;

  apb3_dm_regs #(.FIFO_DEPTH(8)) dut (
    .PCLK       (PCLK),
    .PRESETN    (PRESETN),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR),
    .status_in  (status_in),
    .ctrl_out   (ctrl_out),
    .fifo_dout  (fifo_dout),
    .fifo_valid (fifo_valid),
    .fifo_ready (fifo_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // One APB transfer; waits counts PREADY-low cycles, bounded at 50.
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic pop_in_access, output logic [31:0] rdata,
                          output logic err, output int waits);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    fifo_ready = pop_in_access;
    waits = 0;
    @(negedge PCLK);
    while (!PREADY && waits < 50) begin
      waits++;
      @(negedge PCLK);
    end
    rdata = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; fifo_ready = 1'b0;
  endtask

  task automatic drain(output logic [31:0] first, output logic [31:0] last, output int n);
    n = 0;
    first = 32'h0;
    last = 32'h0;
    fifo_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge PCLK);
      if (!fifo_valid) break;
      if (n == 0) first = fifo_dout;
      last = fifo_dout;
      n++;
      @(posedge PCLK); #1;
    end
    fifo_ready = 1'b0;
  endtask

  task automatic fill(input logic [31:0] base, output int nerr);
    logic [31:0] r;
    logic e;
    int ww;
    nerr = 0;
    for (int i = 0; i < 8; i++) begin
      apb_xfer(1'b1, 8'h0C, base + 32'(i), 1'b0, r, e, ww);
      if (e || ww != 0) nerr++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b0, 8'h00, 32'h0,          32'h0,          1'b0, "ctrl_reset"};
    vt[1]  = '{1'b0, 8'h08, 32'h0,          32'h0,          1'b0, "scratch_reset"};
    vt[2]  = '{1'b0, 8'h10, 32'h0,          32'h0,          1'b0, "level_reset"};
    vt[3]  = '{1'b0, 8'h04, 32'h0,          32'hBEEF_0001,  1'b0, "status_reset"};
    vt[4]  = '{1'b1, 8'h08, 32'hA5A5_5A5A,  32'h0,          1'b0, "scratch_wr"};
    vt[5]  = '{1'b0, 8'h08, 32'h0,          32'hA5A5_5A5A,  1'b0, "scratch_rd"};
    vt[6]  = '{1'b0, 8'h14, 32'h0,          32'h444D_0102,  1'b0, "id_rd"};
    vt[7]  = '{1'b1, 8'h14, 32'h1234_5678,  32'h0,          1'b1, "id_wr"};
    vt[8]  = '{1'b0, 8'h14, 32'h0,          32'h444D_0102,  1'b0, "id_after_wr"};
    vt[9]  = '{1'b0, 8'h40, 32'h0,          32'h0,          1'b1, "unmapped_rd"};
    vt[10] = '{1'b1, 8'h44, 32'hFFFF_FFFF,  32'h0,          1'b1, "unmapped_wr"};
    vt[11] = '{1'b0, 8'h0C, 32'h0,          32'h0,          1'b1, "fifo_data_rd"};
    vt[12] = '{1'b1, 8'h04, 32'h0000_0001,  32'h0,          1'b1, "status_wr"};
    vt[13] = '{1'b1, 8'h00, 32'hDEAD_BEF7,  32'h0,          1'b0, "ctrl_wr"};
    vt[14] = '{1'b0, 8'h00, 32'h0,          32'hDEAD_BEF4,  1'b0, "ctrl_rd_masked"};
    vt[15] = '{1'b0, 8'h0B, 32'h0,          32'hA5A5_5A5A,  1'b0, "scratch_low_bits"};
    vt[16] = '{1'b1, 8'h10, 32'h0000_0005,  32'h0,          1'b1, "level_wr"};
    vt[17] = '{1'b0, 8'h08, 32'h0,          32'hA5A5_5A5A,  1'b0, "scratch_kept"};

    PRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h0;
    PWDATA = 32'h0; fifo_ready = 1'b0; status_in = 16'hBEEF;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_pready", PREADY, 1);
    check("rst_pslverr", PSLVERR, 0);
    check("rst_prdata", PRDATA, 0);
    check("rst_fifo_valid", fifo_valid, 0);
    check("rst_ctrl_out", ctrl_out, 0);
    @(posedge PCLK); #1;
    PRESETN = 1'b1;

    for (int i = 0; i < 18; i++) begin
      apb_xfer(vt[i].wr, vt[i].addr, vt[i].wdata, 1'b0, rd, er, w);
      check({vt[i].name, "_rdata"}, rd, vt[i].exp_rdata);
      check({vt[i].name, "_err"}, er, vt[i].exp_err);
      check({vt[i].name, "_waits"}, w, 0);
    end
    check("ctrl_out_hold", ctrl_out, 32'hDEAD_BEF4);

    // CTRL pulse bits are visible for exactly one cycle.
    apb_xfer(1'b1, 8'h00, 32'h0000_0003, 1'b0, rd, er, w);
    check("ctrl_pulse_seen", ctrl_out, 32'h0000_0003);
    @(posedge PCLK); #1;
    check("ctrl_pulse_clear", ctrl_out, 32'h0);

    fill(32'h100, errs_fill);
    check("fill1_errs", errs_fill, 0);
    apb_xfer(1'b0, 8'h10, 32'h0, 1'b0, rd, er, w);
    check("fill1_level", rd, 8);
    apb_xfer(1'b0, 8'h04, 32'h0, 1'b0, rd, er, w);
    check("fill1_status", rd, 32'hBEEF_0002);
    check("fill1_head", fifo_dout, 32'h100);

`ifdef DM_FIFO_STALL_EN
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h0C; PWDATA = 32'h1234;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    lows = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge PCLK);
      if (!PREADY) lows++;
    end
    check("stall_low_cycles", lows, 5);
    @(posedge PCLK); #1;
    fifo_ready = 1'b1;
    @(negedge PCLK);
    check("stall_release_ready", PREADY, 1);
    check("stall_release_err", PSLVERR, 0);
    @(posedge PCLK); #1;
    fifo_ready = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    apb_xfer(1'b0, 8'h10, 32'h0, 1'b0, rd, er, w);
    check("stall_level", rd, 8);
    drain(first_w, last_w, got);
    check("stall_drain_count", got, 8);
    check("stall_drain_first", first_w, 32'h101);
    check("stall_drain_last", last_w, 32'h1234);
`else
    apb_xfer(1'b1, 8'h0C, 32'h108, 1'b0, rd, er, w);
    check("ovf_push_err", er, 1);
    check("ovf_push_waits", w, 0);
    apb_xfer(1'b0, 8'h04, 32'h0, 1'b0, rd, er, w);
    check("ovf_status", rd, 32'hBEEF_0006);
    apb_xfer(1'b0, 8'h10, 32'h0, 1'b0, rd, er, w);
    check("ovf_level", rd, 8);
    apb_xfer(1'b1, 8'h00, 32'h0000_0002, 1'b0, rd, er, w);
    apb_xfer(1'b0, 8'h04, 32'h0, 1'b0, rd, er, w);
    check("ovf_cleared_status", rd, 32'hBEEF_0002);
    check("ovf_head_intact", fifo_dout, 32'h100);
`endif

    apb_xfer(1'b1, 8'h00, 32'h0000_0001, 1'b0, rd, er, w);
    @(negedge PCLK);
    check("flush1_valid", fifo_valid, 0);
    fill(32'h200, errs_fill);
    check("fill2_errs", errs_fill, 0);
    // Push with a pop in the same access cycle: level holds at full.
    apb_xfer(1'b1, 8'h0C, 32'h208, 1'b1, rd, er, w);
    check("pushpop1_err", er, 0);
    apb_xfer(1'b1, 8'h0C, 32'h209, 1'b1, rd, er, w);
    check("pushpop2_err", er, 0);
    apb_xfer(1'b0, 8'h10, 32'h0, 1'b0, rd, er, w);
    check("pushpop_level", rd, 8);
    check("pushpop_head", fifo_dout, 32'h202);
    apb_xfer(1'b1, 8'h00, 32'h0000_0001, 1'b0, rd, er, w);
    @(negedge PCLK);
    check("flush2_valid", fifo_valid, 0);
    apb_xfer(1'b0, 8'h10, 32'h0, 1'b0, rd, er, w);
    check("flush2_level", rd, 0);

    // Reset in the middle of a full-FIFO push.
    fill(32'h300, errs_fill);
    check("fill3_errs", errs_fill, 0);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h0C; PWDATA = 32'h3FF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
`ifdef DM_FIFO_STALL_EN
    repeat (3) @(negedge PCLK);
    check("rst_mid_stalled", PREADY, 0);
`endif
    @(negedge PCLK);
    PRESETN = 1'b0;
    #1;
    check("rst_mid_pready", PREADY, 1);
    check("rst_mid_pslverr", PSLVERR, 0);
    check("rst_mid_prdata", PRDATA, 0);
    check("rst_mid_fifo_valid", fifo_valid, 0);
    check("rst_mid_ctrl_out", ctrl_out, 0);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESETN = 1'b1;
    apb_xfer(1'b0, 8'h10, 32'h0, 1'b0, rd, er, w);
    check("rst_mid_level", rd, 0);
    apb_xfer(1'b0, 8'h08, 32'h0, 1'b0, rd, er, w);
    check("rst_mid_scratch", rd, 0);

    status_in = 16'h1234;
    apb_xfer(1'b0, 8'h04, 32'h0, 1'b0, rd, er, w);
    check("status_live", rd, 32'h1234_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
